keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//   Parametrised matrix-keypad scanner: drives one column at a time, samples
//   the rows, debounces whole-frame results and reports press/release events
//   with an encoded key index. Sits between the board keypad pins and the
//   countdown control logic. Successor to the fixed 4x4 undebounced scanner.
// PARAMETERS
//   ROWS      4  number of row inputs (>=1)
//   COLS      4  number of column outputs (>=2)
//   SETTLE    4  cycles each column is driven; rows sampled on the last (>=3)
//   DEBOUNCE  3  consecutive identical frames needed to accept a change (>=1)
//   CODE_W = $clog2(ROWS*COLS) (localparam)
// PORTS
//   scan_clk     in   1       scan clock, all logic on rising edge
//   rst_n        in   1       asynchronous reset, active low
//   row_n        in   ROWS    row lines, active low (pulled up), asynchronous
//   col_n        out  COLS    column drive, one-hot active low, registered
//   keydown      out  1       debounced: at least one key held
//   key_code     out  CODE_W  debounced key index = row*COLS + col
//   key_valid    out  1       1-cycle pulse: new single key accepted
//   key_release  out  1       1-cycle pulse: keydown fell
//   multi_key    out  1       debounced: >1 key held in accepted frame
// BEHAVIOUR
//   Reset (async assert, sync release): col_n all 1s, all outputs 0, counters
//     0, candidate/stable = "no key". First cycle after release drives col 0.
//   row_n passes through a 2-flop synchroniser before use.
//   Scan: col counter 0..COLS-1, slot counter 0..SETTLE-1. col_n[c]=0 for the
//     whole slot; the synchronised row_n is sampled in slot cycle SETTLE-1;
//     then col wraps COLS-1 -> 0 with no idle gap. Frame = COLS*SETTLE cycles.
//   Frame result: pressed bit, count>1 bit, code of the lowest pressed index
//     (col-major scan order, lowest row within column; any frame key
//     minimising row*COLS+col is reported). Built from the samples and
//     complete at the last sample of col COLS-1.
//   Debounce at each frame end: if result == candidate, cnt <= min(cnt+1,
//     DEBOUNCE); else candidate <= result, cnt <= 1. When cnt reaches
//     DEBOUNCE and candidate != stable: stable <= candidate, events issued.
//   Events, in the cycle after the accepting frame end:
//     none->single or single A->single B: key_valid=1, key_code=new.
//     any->multi: multi_key=1, keydown=1, no key_valid, key_code unchanged.
//     multi->single: multi_key=0, key_valid=1, key_code=new.
//     pressed->none: key_release=1, keydown=0, key_code holds last value.
//   key_valid and key_release never coincide. Outputs change only on events.
//   Latency: key steady before frame n starts -> key_valid one cycle after
//     the end of frame n+DEBOUNCE-1.
//   Glitch shorter than DEBOUNCE frames: candidate resets, no event.
//   Reset mid-frame: scan restarts at col 0, debounce state cleared, no
//     pulses emitted on or after reset release for a key already held until
//     DEBOUNCE frames pass (it is then reported as a fresh press).
// TESTING (defaults: frame = 16 cycles)
//   Reset release, no keys, 64 cycles -> col_n cycles 1110,1101,1011,0111
//     each 4 cycles; all outputs stay 0.
//   Model keypad: hold row 2/col 1 -> exactly one key_valid, key_code=9,
//     keydown=1, 1 cycle after 3rd matching frame end; release -> one
//     key_release 3 frames later.
//   Press row 0/col 3 for 2 frames only, then release -> no events.
//   Hold codes 5 and 10 together -> multi_key=1, keydown=1, no key_valid;
//     release 10 -> key_valid, key_code=5, multi_key=0.
//   Hold code 0, switch directly to 15 -> key_valid, key_code=15, no
//     key_release between; assert rst_n=0 mid-frame -> all outputs 0 at once.
//   Rerun with ROWS=3, COLS=5, SETTLE=3, DEBOUNCE=1: press row 2/col 4 ->
//     key_code=14 after one frame (15 cycles).

Source files
------------

// File: rtl/keypad_scanner_if.sv
// Keypad pin and event bundle between the matrix scanner (master) and
// whatever observes the keypad (slave).
interface keypad_scanner_if #(
   parameter int unsigned ROWS = 4,
   parameter int unsigned COLS = 4
);
   localparam int unsigned CODE_W = $clog2(ROWS * COLS);

   logic [ROWS-1:0]   row_n;
   logic [COLS-1:0]   col_n;
   logic              keydown;
   logic [CODE_W-1:0] key_code;
   logic              key_valid;
   logic              key_release;
   logic              multi_key;

   modport master (
      input  row_n,
      output col_n, keydown, key_code, key_valid, key_release, multi_key
   );

   modport slave (
      output row_n,
      input  col_n, keydown, key_code, key_valid, key_release, multi_key
   );
endinterface

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column-at-a-time drive, synchronised row sampling,
// whole-frame debounce and press/release/multi-key event reporting.
module keypad_scanner #(
   parameter int unsigned ROWS     = 4,
   parameter int unsigned COLS     = 4,
   parameter int unsigned SETTLE   = 4,
   parameter int unsigned DEBOUNCE = 3
) (
   input  logic              scan_clk,
   input  logic              rst_n,
   keypad_scanner_if.master  kp
);
   localparam int unsigned CODE_W = $clog2(ROWS * COLS);
   localparam int unsigned COL_W  = $clog2(COLS);
   localparam int unsigned SLOT_W = $clog2(SETTLE);
   localparam int unsigned CNT_W  = $clog2(DEBOUNCE + 1);

   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SETTLE - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE);

   typedef enum logic [1:0] {
      ST_NONE   = 2'd0,
      ST_SINGLE = 2'd1,
      ST_MULTI  = 2'd2
   } state_t;

   typedef struct packed {
      logic              pressed;
      logic              multi;
      logic [CODE_W-1:0] code;
   } frame_t;

   // Two-flop synchroniser; idle rows read as all released.
   logic [ROWS-1:0] row_s1, row_s2;

   always_ff @(posedge scan_clk or negedge rst_n) begin
      if (!rst_n) begin
         row_s1 <= '1;
         row_s2 <= '1;
      end else begin
         row_s1 <= kp.row_n;
         row_s2 <= row_s1;
      end
   end

   // Column/slot scan; 'running' holds col_n idle for the first cycle after reset.
   logic              running;
   logic [COL_W-1:0]  col_cnt;
   logic [SLOT_W-1:0] slot_cnt;
   logic [COLS-1:0]   col_n_q;
   logic [COL_W-1:0]  col_nxt_c;
   logic              sample_en_c;
   logic              frame_end_c;

   assign sample_en_c = running && (slot_cnt == SLOT_LAST);
   assign frame_end_c = sample_en_c && (col_cnt == COL_LAST);
   assign col_nxt_c   = (col_cnt == COL_LAST) ? '0 : col_cnt + COL_W'(1);

   always_ff @(posedge scan_clk or negedge rst_n) begin
      if (!rst_n) begin
         running  <= 1'b0;
         col_cnt  <= '0;
         slot_cnt <= '0;
         col_n_q  <= '1;
      end else if (!running) begin
         running <= 1'b1;
         col_n_q <= ~(COLS'(1));
      end else if (sample_en_c) begin
         slot_cnt <= '0;
         col_cnt  <= col_nxt_c;
         col_n_q  <= ~(COLS'(1) << col_nxt_c);
      end else begin
         slot_cnt <= slot_cnt + SLOT_W'(1);
      end
   end

   assign kp.col_n = col_n_q;

   // Lowest pressed row in the driven column, plus a second-hit flag.
   logic              col_hit_c;
   logic              col_multi_c;
   logic [CODE_W-1:0] col_code_c;

   always_comb begin
      col_hit_c   = 1'b0;
      col_multi_c = 1'b0;
      col_code_c  = '0;
      for (int r = int'(ROWS) - 1; r >= 0; r--) begin
         if (!row_s2[r]) begin
            col_multi_c = col_multi_c | col_hit_c;
            col_hit_c   = 1'b1;
            col_code_c  = CODE_W'(r * int'(COLS) + int'(col_cnt));
         end
      end
   end

   // Running frame result merged with the current column sample.
   frame_t acc_q;
   frame_t frame_c;

   always_comb begin
      frame_c.pressed = acc_q.pressed | col_hit_c;
      frame_c.multi   = acc_q.multi | col_multi_c | (acc_q.pressed & col_hit_c);
      frame_c.code    = (col_hit_c && (!acc_q.pressed || (col_code_c < acc_q.code)))
                        ? col_code_c : acc_q.code;
   end

   // Debounce: count consecutive identical frame results.
   frame_t           cand_q;
   frame_t           cand_nxt_c;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_nxt_c;

   always_comb begin
      cand_nxt_c = cand_q;
      cnt_nxt_c  = cnt_q;
      if (frame_end_c) begin
         if (frame_c == cand_q) begin
            cnt_nxt_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
         end else begin
            cand_nxt_c = frame_c;
            cnt_nxt_c  = CNT_W'(1);
         end
      end
   end

   always_ff @(posedge scan_clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q  <= '0;
         cand_q <= '0;
         cnt_q  <= '0;
      end else if (sample_en_c) begin
         acc_q <= frame_end_c ? frame_t'('0) : frame_c;
         if (frame_end_c) begin
            cand_q <= cand_nxt_c;
            cnt_q  <= cnt_nxt_c;
         end
      end
   end

   // Accepted-state FSM; its transitions produce the registered events.
   state_t            state_q, state_nxt;
   state_t            cand_kind_c;
   logic [CODE_W-1:0] stable_code_q, stable_code_nxt;
   logic              accept_c;

   logic              keydown_q, keydown_nxt;
   logic [CODE_W-1:0] code_q, code_nxt;
   logic              valid_q, valid_nxt;
   logic              release_q, release_nxt;
   logic              multi_q, multi_nxt;

   always_comb begin
      if (!cand_nxt_c.pressed)   cand_kind_c = ST_NONE;
      else if (cand_nxt_c.multi) cand_kind_c = ST_MULTI;
      else                       cand_kind_c = ST_SINGLE;
   end

   assign accept_c = frame_end_c && (cnt_nxt_c == CNT_MAX) &&
                     ((cand_kind_c != state_q) || (cand_nxt_c.code != stable_code_q));

   always_comb begin
      state_nxt       = state_q;
      stable_code_nxt = stable_code_q;
      keydown_nxt     = keydown_q;
      code_nxt        = code_q;
      multi_nxt       = multi_q;
      valid_nxt       = 1'b0;
      release_nxt     = 1'b0;
      if (accept_c) begin
         state_nxt       = cand_kind_c;
         stable_code_nxt = cand_nxt_c.code;
         case (cand_kind_c)
            ST_NONE: begin
               release_nxt = (state_q != ST_NONE);
               keydown_nxt = 1'b0;
               multi_nxt   = 1'b0;
            end
            ST_MULTI: begin
               keydown_nxt = 1'b1;
               multi_nxt   = 1'b1;
            end
            default: begin
               valid_nxt   = 1'b1;
               code_nxt    = cand_nxt_c.code;
               keydown_nxt = 1'b1;
               multi_nxt   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge scan_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_NONE;
         stable_code_q <= '0;
         keydown_q     <= 1'b0;
         code_q        <= '0;
         multi_q       <= 1'b0;
         valid_q       <= 1'b0;
         release_q     <= 1'b0;
      end else begin
         state_q       <= state_nxt;
         stable_code_q <= stable_code_nxt;
         keydown_q     <= keydown_nxt;
         code_q        <= code_nxt;
         multi_q       <= multi_nxt;
         valid_q       <= valid_nxt;
         release_q     <= release_nxt;
      end
   end

   assign kp.keydown     = keydown_q;
   assign kp.key_code    = code_q;
   assign kp.key_valid   = valid_q;
   assign kp.key_release = release_q;
   assign kp.multi_key   = multi_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: frame-level keypad model predicts
// events, a monitor matches them against DUT output changes.
module tb_keypad_scanner;
   localparam int unsigned ROWS = 4, COLS = 4, SETTLE = 4, DEB = 3;
   localparam int unsigned F    = COLS * SETTLE;
   localparam int unsigned NK   = ROWS * COLS;
   localparam int unsigned RB = 3, CB = 5, SB = 3, DB = 1;
   localparam int unsigned FB = CB * SB;

   logic scan_clk = 1'b0;
   logic rst_n, rst_b_n;
   always #5 scan_clk = ~scan_clk;

   keypad_scanner_if #(.ROWS(ROWS), .COLS(COLS)) kp_a();
   keypad_scanner_if #(.ROWS(RB),   .COLS(CB))   kp_b();

   keypad_scanner #(.ROWS(ROWS), .COLS(COLS), .SETTLE(SETTLE), .DEBOUNCE(DEB)) dut_a (
      .scan_clk(scan_clk), .rst_n(rst_n), .kp(kp_a));
   keypad_scanner #(.ROWS(RB), .COLS(CB), .SETTLE(SB), .DEBOUNCE(DB)) dut_b (
      .scan_clk(scan_clk), .rst_n(rst_b_n), .kp(kp_b));

   // Physical keypad: a held key pulls its row low while its column is driven.
   logic [NK-1:0]    held_a;
   logic [RB*CB-1:0] held_b;

   always_comb begin
      kp_a.row_n = '1;
      for (int r = 0; r < int'(ROWS); r++)
         for (int c = 0; c < int'(COLS); c++)
            if (held_a[r*int'(COLS)+c] && !kp_a.col_n[c]) kp_a.row_n[r] = 1'b0;
   end

   always_comb begin
      kp_b.row_n = '1;
      for (int r = 0; r < int'(RB); r++)
         for (int c = 0; c < int'(CB); c++)
            if (held_b[r*int'(CB)+c] && !kp_b.col_n[c]) kp_b.row_n[r] = 1'b0;
   end

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected visible event and the output levels that follow it.
   typedef struct {
      int unsigned cyc;
      logic        vld;
      logic        rel;
      logic        kd;
      logic        mk;
      logic [3:0]  code;
   } ev_t;

   ev_t exp_q[$];

   // Frame-level reference model: -1 none, 0..15 single, 64+low multi.
   int          hist[$];
   int          stable_res;
   int unsigned fidx;
   logic        exp_kd, exp_mk;
   logic [3:0]  exp_code;

   function automatic int frame_result(input logic [NK-1:0] s);
      int low;
      low = 0;
      if (s == '0) return -1;
      for (int i = int'(NK) - 1; i >= 0; i--) if (s[i]) low = i;
      if ($countones(s) > 1) return 64 + low;
      return low;
   endfunction

   task automatic model_reset();
      hist.delete();
      stable_res = -1;
      fidx       = 0;
      exp_kd     = 1'b0;
      exp_mk     = 1'b0;
      exp_code   = '0;
   endtask

   task automatic model_frame(input logic [NK-1:0] s);
      int  r;
      bit  same;
      ev_t e;
      r = frame_result(s);
      hist.push_back(r);
      if (hist.size() > DEB) void'(hist.pop_front());
      same = (hist.size() == DEB);
      foreach (hist[i]) if (hist[i] != r) same = 1'b0;
      if (same && r != stable_res) begin
         e.cyc = (fidx + 1) * F + 1;
         e.vld = 1'b0; e.rel = 1'b0;
         e.kd = exp_kd; e.mk = exp_mk; e.code = exp_code;
         if (r < 0) begin
            e.rel = 1'b1; e.kd = 1'b0; e.mk = 1'b0;
         end else if (r >= 64) begin
            e.kd = 1'b1; e.mk = 1'b1;
         end else begin
            e.vld = 1'b1; e.kd = 1'b1; e.mk = 1'b0; e.code = 4'(r);
         end
         if (e.vld || e.rel || e.kd != exp_kd || e.mk != exp_mk) exp_q.push_back(e);
         exp_kd = e.kd; exp_mk = e.mk; exp_code = e.code;
         stable_res = r;
      end
      fidx++;
   endtask

   // Called at #1 after a frame-start edge; holds the set for n whole frames.
   task automatic apply_frames(input logic [NK-1:0] s, input int n);
      for (int i = 0; i < n; i++) begin
         held_a = s;
         model_frame(s);
         repeat (F) @(posedge scan_clk);
         #1;
      end
   endtask

   // Monitor: scan pattern every cycle, events whenever any output moves.
   int unsigned      cyc;
   logic             p_kd, p_mk;
   logic [3:0]       p_code;
   ev_t              mon_e;
   logic [COLS-1:0]  exp_col;

   always @(posedge scan_clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   always @(negedge scan_clk) begin
      if (!rst_n) begin
         p_kd = 1'b0; p_mk = 1'b0; p_code = '0;
      end else if (cyc >= 1) begin
         exp_col = ~(COLS'(1) << (((cyc - 1) / SETTLE) % COLS));
         check("col_n_scan", kp_a.col_n, exp_col);
         if (kp_a.key_valid || kp_a.key_release || kp_a.keydown != p_kd ||
             kp_a.multi_key != p_mk || kp_a.key_code != p_code) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL spurious_event: cyc=%0d vld=%0b rel=%0b kd=%0b mk=%0b code=%0d, expected no event",
                        cyc, kp_a.key_valid, kp_a.key_release, kp_a.keydown, kp_a.multi_key, kp_a.key_code);
            end else begin
               mon_e = exp_q.pop_front();
               check("event_cycle", cyc, mon_e.cyc);
               check("key_valid",   kp_a.key_valid, mon_e.vld);
               check("key_release", kp_a.key_release, mon_e.rel);
               check("keydown",     kp_a.keydown, mon_e.kd);
               check("multi_key",   kp_a.multi_key, mon_e.mk);
               check("key_code",    kp_a.key_code, mon_e.code);
            end
         end
         p_kd = kp_a.keydown; p_mk = kp_a.multi_key; p_code = kp_a.key_code;
      end
   end

   function automatic logic [NK-1:0] rand_set();
      int unsigned k;
      logic [NK-1:0] s;
      k = $urandom_range(0, 9);
      s = '0;
      if (k >= 3) s[$urandom_range(0, NK - 1)] = 1'b1;
      if (k >= 7) s[$urandom_range(0, NK - 1)] = 1'b1;
      if (k >= 9) s[$urandom_range(0, NK - 1)] = 1'b1;
      return s;
   endfunction

   int unsigned e;

   initial begin
      rst_n = 1'b0; rst_b_n = 1'b0;
      held_a = '0; held_b = '0;
      model_reset();
      repeat (3) @(posedge scan_clk);
      #1;
      check("rst_col_n",       kp_a.col_n, 4'hF);
      check("rst_keydown",     kp_a.keydown, 0);
      check("rst_key_code",    kp_a.key_code, 0);
      check("rst_key_valid",   kp_a.key_valid, 0);
      check("rst_key_release", kp_a.key_release, 0);
      check("rst_multi_key",   kp_a.multi_key, 0);
      check("rst_b_col_n",     kp_b.col_n, 5'h1F);

      @(negedge scan_clk); #2 rst_n = 1'b1;
      @(posedge scan_clk); #1;

      apply_frames('0, 4);                                   // idle scan
      apply_frames(NK'(1) << 9, 4);  apply_frames('0, 4);    // row 2 / col 1
      apply_frames(NK'(1) << 3, 2);  apply_frames('0, 4);    // short glitch
      apply_frames((NK'(1) << 5) | (NK'(1) << 10), 4);       // two keys
      apply_frames(NK'(1) << 5, 4);  apply_frames('0, 4);
      apply_frames(NK'(1) << 0, 4);                          // direct switch
      apply_frames(NK'(1) << 15, 4); apply_frames('0, 4);

      for (int i = 0; i < 30; i++) apply_frames(rand_set(), int'($urandom_range(1, 5)));
      apply_frames('0, DEB + 1);

      // Reset in the middle of a frame while a key is held.
      apply_frames(NK'(1) << 6, 4);
      repeat (7) @(posedge scan_clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_col_n",       kp_a.col_n, 4'hF);
      check("midrst_keydown",     kp_a.keydown, 0);
      check("midrst_key_code",    kp_a.key_code, 0);
      check("midrst_key_valid",   kp_a.key_valid, 0);
      check("midrst_key_release", kp_a.key_release, 0);
      check("midrst_multi_key",   kp_a.multi_key, 0);
      model_reset();
      repeat (2) @(negedge scan_clk);
      #2 rst_n = 1'b1;
      @(posedge scan_clk); #1;
      apply_frames(NK'(1) << 6, 4);
      apply_frames('0, 4);
      repeat (2) @(negedge scan_clk);
      check("pending_events", exp_q.size(), 0);

      // Small configuration: 3x5, SETTLE 3, single-frame debounce.
      @(negedge scan_clk); #2 rst_b_n = 1'b1;
      @(posedge scan_clk); #1;
      held_b = (RB*CB)'(1) << 14;
      e = 1;
      @(negedge scan_clk);
      while (!kp_b.key_valid && e < 4 * FB) begin
         @(negedge scan_clk); e++;
      end
      check("b_valid_seen",  kp_b.key_valid, 1);
      check("b_valid_cycle", e, FB + 1);
      check("b_key_code",    kp_b.key_code, 14);
      check("b_keydown",     kp_b.keydown, 1);
      check("b_multi_key",   kp_b.multi_key, 0);
      held_b = '0;
      @(negedge scan_clk); e++;
      while (!kp_b.key_release && e < 8 * FB) begin
         @(negedge scan_clk); e++;
      end
      check("b_release_seen",  kp_b.key_release, 1);
      check("b_release_cycle", e, 2 * FB + 1);
      check("b_release_kd",    kp_b.keydown, 0);
      check("b_release_code",  kp_b.key_code, 14);
      check("b_release_vld",   kp_b.key_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
